// File: rtl/reconfig_pkg.sv
// Shared types and defaults for the core reconfiguration sequencer.
package reconfig_pkg;

  localparam int DEFAULT_HOLD_CYC  = 4;
  localparam int DEFAULT_TIMEOUT_W = 16;
  // HOLD_CYC is limited to 2..16, so a 4-bit hold counter always suffices.
  localparam int HOLD_W            = 4;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    DRAIN_HOLD,
    BEGIN_CONS,
    CONSOLIDATE,
    HALT,
    LOAD,
    FINISH,
    ABORT
  } state_t;

  typedef struct packed {
    state_t              state;
    logic                pendValid;
    logic [HOLD_W-1:0]   holdCnt;
    logic                drainCntClear;
  } seqDbg_t;

  function automatic logic isHoldState(input state_t s);
    return (s == DRAIN_HOLD) || (s == HALT) || (s == LOAD) || (s == FINISH);
  endfunction

endpackage

// File: rtl/reconfig_timer.sv
// Loadable saturating counter with zero flag; counts down by default, up when COUNT_UP is set.
module reconfig_timer #(
  parameter int W        = 4,
  parameter bit COUNT_UP = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (step) begin
      if (COUNT_UP) begin
        if (count != '1) count <= count + W'(1);
      end else begin
        if (count != '0) count <= count - W'(1);
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/reconfig_sequencer.sv
// Drains the pipeline, consolidates registers and applies a new core configuration,
// with a one-deep request queue, drain timeout and a skip path for unchanged configs.
module reconfig_sequencer
  import reconfig_pkg::*;
#(
  parameter int               CFG_W     = 64,
  parameter logic [CFG_W-1:0] RESET_CFG = '1,
  parameter int               HOLD_CYC  = DEFAULT_HOLD_CYC,
  parameter int               TIMEOUT_W = DEFAULT_TIMEOUT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [CFG_W-1:0]     req_cfg_i,
  input  logic [TIMEOUT_W-1:0] drain_timeout_i,
  input  logic                 pipe_empty_i,
  input  logic                 consolidate_done_i,
  output logic                 squash_o,
  output logic                 stall_fetch_o,
  output logic                 pipe_drained_o,
  output logic                 begin_consol_o,
  output logic                 reconfig_flag_o,
  output logic                 load_cfg_o,
  output logic                 done_o,
  output logic                 abort_o,
  output logic                 busy_o,
  output logic [CFG_W-1:0]     active_cfg_o,
  output seqDbg_t              dbg
);

  // Handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; ready depends only on the pending slot and reset.

  state_t                state;
  state_t                nextState;
  logic                  pendValid;
  logic [CFG_W-1:0]      pendCfg;
  logic [CFG_W-1:0]      wrkCfg;
  logic                  accept;
  logic                  startValid;
  logic [CFG_W-1:0]      startCfg;
  logic                  holdLoad;
  logic                  holdStep;
  logic [HOLD_W-1:0]     holdCnt;
  logic                  holdZero;
  logic                  toLoad;
  logic                  toStep;
  logic [TIMEOUT_W-1:0]  toCnt;
  logic                  toZero;
  logic [TIMEOUT_W:0]    toNext;
  logic                  toHit;

  assign req_ready_o = !pendValid && !reset;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    startValid = (state == IDLE) && (pendValid || accept);
    startCfg   = pendValid ? pendCfg : req_cfg_i;
    toNext     = {1'b0, toCnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
    // Fires on the DRAIN cycle that would be the drain_timeout_i-th non-empty one.
    toHit      = (drain_timeout_i != '0) && (toNext >= {1'b0, drain_timeout_i});
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (startValid) nextState = (startCfg == active_cfg_o) ? FINISH : DRAIN;
      end
      DRAIN: begin
        if (pipe_empty_i) nextState = DRAIN_HOLD;
        else if (toHit)   nextState = ABORT;
      end
      DRAIN_HOLD:  if (holdZero) nextState = BEGIN_CONS;
      BEGIN_CONS:  nextState = CONSOLIDATE;
      CONSOLIDATE: if (consolidate_done_i) nextState = HALT;
      HALT:        if (holdZero) nextState = LOAD;
      LOAD:        if (holdZero) nextState = FINISH;
      FINISH:      if (holdZero) nextState = IDLE;
      ABORT:       nextState = IDLE;
      default:     nextState = IDLE;
    endcase
  end

  always_comb begin
    holdLoad = isHoldState(nextState) && (nextState != state);
    holdStep = isHoldState(state);
    toLoad   = (nextState == DRAIN) && (state != DRAIN);
    toStep   = (state == DRAIN) && !pipe_empty_i;
  end

  reconfig_timer #(
    .W        (HOLD_W),
    .COUNT_UP (1'b0)
  ) u_hold_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (holdLoad),
    .loadVal (HOLD_W'(HOLD_CYC - 1)),
    .step    (holdStep),
    .count   (holdCnt),
    .zero    (holdZero)
  );

  reconfig_timer #(
    .W        (TIMEOUT_W),
    .COUNT_UP (1'b1)
  ) u_drain_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (toLoad),
    .loadVal ('0),
    .step    (toStep),
    .count   (toCnt),
    .zero    (toZero)
  );

  // Outputs are registered from nextState so each one lines up with the state it decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pendValid       <= 1'b0;
      pendCfg         <= '0;
      wrkCfg          <= RESET_CFG;
      active_cfg_o    <= RESET_CFG;
      squash_o        <= 1'b0;
      stall_fetch_o   <= 1'b0;
      pipe_drained_o  <= 1'b0;
      begin_consol_o  <= 1'b0;
      reconfig_flag_o <= 1'b0;
      load_cfg_o      <= 1'b0;
      done_o          <= 1'b0;
      abort_o         <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state <= nextState;

      if (accept && (state != IDLE)) begin
        pendValid <= 1'b1;
        pendCfg   <= req_cfg_i;
      end else if ((state == IDLE) && pendValid) begin
        pendValid <= 1'b0;
      end

      if (startValid) wrkCfg <= startCfg;
      if ((state == LOAD) && (nextState != LOAD)) active_cfg_o <= wrkCfg;

      squash_o        <= (nextState == DRAIN) && (state != DRAIN);
      stall_fetch_o   <= (nextState == DRAIN) || (nextState == DRAIN_HOLD) ||
                         (nextState == BEGIN_CONS) || (nextState == CONSOLIDATE) ||
                         (nextState == HALT) || (nextState == LOAD);
      pipe_drained_o  <= (nextState == DRAIN_HOLD) || (nextState == BEGIN_CONS) ||
                         (nextState == CONSOLIDATE) || (nextState == HALT) ||
                         (nextState == LOAD);
      begin_consol_o  <= (nextState == BEGIN_CONS);
      reconfig_flag_o <= (nextState == HALT) || (nextState == LOAD);
      load_cfg_o      <= (nextState == LOAD);
      done_o          <= (nextState == FINISH);
      abort_o         <= (nextState == ABORT);
      busy_o          <= (nextState != IDLE);
    end
  end

  always_comb begin
    dbg               = '0;
    dbg.state         = state;
    dbg.pendValid     = pendValid;
    dbg.holdCnt       = holdCnt;
    dbg.drainCntClear = toZero;
  end

endmodule

// File: tb/tb_reconfig_sequencer.sv
// Directed bench for reconfig_sequencer: normal, timeout, skip, queueing and reset-abort sequences.
module tb_reconfig_sequencer;
  import reconfig_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [7:0]  req_cfg_i = '0;
  logic [15:0] drain_timeout_i = '0;
  logic        pipe_empty_i = 1'b0;
  logic        consolidate_done_i = 1'b0;
  logic        squash_o, stall_fetch_o, pipe_drained_o, begin_consol_o;
  logic        reconfig_flag_o, load_cfg_o, done_o, abort_o, busy_o;
  logic [7:0]  active_cfg_o;
  seqDbg_t     dbg;
  logic [8:0]  flags;

  int nTests = 0;
  int nFail  = 0;

  reconfig_sequencer #(
    .CFG_W     (8),
    .RESET_CFG (8'hFF),
    .HOLD_CYC  (4),
    .TIMEOUT_W (16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_cfg_i          (req_cfg_i),
    .drain_timeout_i    (drain_timeout_i),
    .pipe_empty_i       (pipe_empty_i),
    .consolidate_done_i (consolidate_done_i),
    .squash_o           (squash_o),
    .stall_fetch_o      (stall_fetch_o),
    .pipe_drained_o     (pipe_drained_o),
    .begin_consol_o     (begin_consol_o),
    .reconfig_flag_o    (reconfig_flag_o),
    .load_cfg_o         (load_cfg_o),
    .done_o             (done_o),
    .abort_o            (abort_o),
    .busy_o             (busy_o),
    .active_cfg_o       (active_cfg_o),
    .dbg                (dbg)
  );

  always #5 clk = ~clk;

  // {squash, stall, drained, begin_consol, reconfig_flag, load_cfg, done, abort, busy}
  assign flags = {squash_o, stall_fetch_o, pipe_drained_o, begin_consol_o,
                  reconfig_flag_o, load_cfg_o, done_o, abort_o, busy_o};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input int cyc, input state_t st,
                            input logic [8:0] fl, input logic [7:0] act);
    check($sformatf("%s c%0d state", tag, cyc), 32'(dbg.state), 32'(st));
    check($sformatf("%s c%0d flags", tag, cyc), 32'(flags), 32'(fl));
    check($sformatf("%s c%0d active", tag, cyc), 32'(active_cfg_o), 32'(act));
  endtask

  // Hand-derived timeline for 8'h3C accepted in cycle 0, pipe empty from 5, consolidate done in 12.
  function automatic void expNormal(input int cyc, output state_t st, output logic [8:0] fl,
                                    output logic [7:0] act);
    act = (cyc >= 21) ? 8'h3C : 8'hFF;
    if (cyc == 1)       begin st = DRAIN;       fl = 9'h181; end
    else if (cyc <= 5)  begin st = DRAIN;       fl = 9'h081; end
    else if (cyc <= 9)  begin st = DRAIN_HOLD;  fl = 9'h0C1; end
    else if (cyc == 10) begin st = BEGIN_CONS;  fl = 9'h0E1; end
    else if (cyc <= 12) begin st = CONSOLIDATE; fl = 9'h0C1; end
    else if (cyc <= 16) begin st = HALT;        fl = 9'h0D1; end
    else if (cyc <= 20) begin st = LOAD;        fl = 9'h0D9; end
    else if (cyc <= 24) begin st = FINISH;      fl = 9'h005; end
    else                begin st = IDLE;        fl = 9'h000; end
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    state_t     st;
    logic [8:0] fl;
    logic [7:0] act;

    // Reset state
    reset = 1'b1;
    tick;
    tick;
    check("reset ready", 32'(req_ready_o), 32'd0);
    checkCycle("reset", 0, IDLE, 9'h000, 8'hFF);
    reset = 1'b0;
    #1;
    check("post-reset ready", 32'(req_ready_o), 32'd1);

    // Normal reconfiguration to 8'h3C
    req_valid_i = 1'b1;
    req_cfg_i   = 8'h3C;
    tick;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      pipe_empty_i       = (c >= 5);
      consolidate_done_i = (c == 12);
      expNormal(c, st, fl, act);
      checkCycle("normal", c, st, fl, act);
      tick;
    end
    pipe_empty_i       = 1'b0;
    consolidate_done_i = 1'b0;

    // Drain timeout of 3 non-empty cycles
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drain_timeout_i = 16'd3;
    req_valid_i     = 1'b1;
    req_cfg_i       = 8'h55;
    tick;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 1)      checkCycle("timeout", c, DRAIN, 9'h181, 8'hFF);
      else if (c <= 3) checkCycle("timeout", c, DRAIN, 9'h081, 8'hFF);
      else if (c == 4) checkCycle("timeout", c, ABORT, 9'h003, 8'hFF);
      else             checkCycle("timeout", c, IDLE,  9'h000, 8'hFF);
      tick;
    end

    // Pipe empty wins over the timeout in the same cycle
    req_valid_i = 1'b1;
    req_cfg_i   = 8'h66;
    tick;
    req_valid_i = 1'b0;
    checkCycle("prio", 1, DRAIN, 9'h181, 8'hFF);
    tick;
    checkCycle("prio", 2, DRAIN, 9'h081, 8'hFF);
    tick;
    pipe_empty_i = 1'b1;
    checkCycle("prio", 3, DRAIN, 9'h081, 8'hFF);
    tick;
    pipe_empty_i = 1'b0;
    checkCycle("prio", 4, DRAIN_HOLD, 9'h0C1, 8'hFF);

    // Zero timeout never aborts
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drain_timeout_i = 16'd0;
    req_valid_i     = 1'b1;
    req_cfg_i       = 8'h77;
    tick;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      check($sformatf("notimeout c%0d state", c), 32'(dbg.state), 32'(DRAIN));
      check($sformatf("notimeout c%0d abort", c), 32'(abort_o), 32'd0);
      tick;
    end

    // Skip path: requested config already active
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req_valid_i = 1'b1;
    req_cfg_i   = 8'hFF;
    tick;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) checkCycle("skip", c, FINISH, 9'h005, 8'hFF);
      else        checkCycle("skip", c, IDLE,   9'h000, 8'hFF);
      tick;
    end

    // Queueing: 8'h0F accepted in CONSOLIDATE, third request refused
    req_valid_i = 1'b1;
    req_cfg_i   = 8'h3C;
    tick;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      pipe_empty_i       = (c >= 5);
      consolidate_done_i = (c == 12);
      if (c == 11) begin
        req_valid_i = 1'b1;
        req_cfg_i   = 8'h0F;
        check("queue second ready", 32'(req_ready_o), 32'd1);
      end else if (c == 12) begin
        req_valid_i = 1'b1;
        req_cfg_i   = 8'hAA;
        check("queue third ready", 32'(req_ready_o), 32'd0);
      end else begin
        req_valid_i = 1'b0;
      end
      if (c == 25) check("queue idle ready", 32'(req_ready_o), 32'd0);
      expNormal(c, st, fl, act);
      checkCycle("queue", c, st, fl, act);
      tick;
    end
    consolidate_done_i = 1'b0;
    check("queue drain ready", 32'(req_ready_o), 32'd1);
    for (int c = 26; c <= 33; c++) begin
      if (c == 26)      checkCycle("queue2", c, DRAIN,       9'h181, 8'h3C);
      else if (c <= 30) checkCycle("queue2", c, DRAIN_HOLD,  9'h0C1, 8'h3C);
      else if (c == 31) checkCycle("queue2", c, BEGIN_CONS,  9'h0E1, 8'h3C);
      else              checkCycle("queue2", c, CONSOLIDATE, 9'h0C1, 8'h3C);
      if (c == 33) begin
        reset = 1'b1;
        #1;
        check("consol reset ready", 32'(req_ready_o), 32'd0);
      end
      tick;
    end

    // Reset taken mid-CONSOLIDATE
    reset = 1'b0;
    checkCycle("consreset", 34, IDLE, 9'h000, 8'hFF);
    for (int c = 35; c <= 38; c++) begin
      tick;
      checkCycle("consreset", c, IDLE, 9'h000, 8'hFF);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
